// File: rtl/wb_merge.sv
// Writeback merge: two fixed-latency ALU pipes plus a queued long-latency
// stream merged onto the two register-file write ports without collisions.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   src0_* / src1_*       ALU results (always accepted); src1 is younger
//   src2_* / src2_ready   long-latency results into a QDEPTH-entry FIFO
//   flush                 drop every queued src2 result
//   wen1/waddr1/wdata1    register-file write port 1 (registered)
//   wen2/waddr2/wdata2    register-file write port 2 (registered)
//   q_count               FIFO occupancy (registered)
module wb_merge #(
    parameter int GRLEN  = 32,
    parameter int QDEPTH = 4,
    parameter int CW     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src0_valid,
    input  logic [4:0]       src0_addr,
    input  logic [GRLEN-1:0] src0_data,
    input  logic             src1_valid,
    input  logic [4:0]       src1_addr,
    input  logic [GRLEN-1:0] src1_data,
    input  logic             src2_valid,
    output logic             src2_ready,
    input  logic [4:0]       src2_addr,
    input  logic [GRLEN-1:0] src2_data,
    input  logic             flush,
    output logic             wen1,
    output logic [4:0]       waddr1,
    output logic [GRLEN-1:0] wdata1,
    output logic             wen2,
    output logic [4:0]       waddr2,
    output logic [GRLEN-1:0] wdata2,
    output logic [CW-1:0]    q_count
);

    localparam int PW = $clog2(QDEPTH);

    logic [4:0]       q_addr [QDEPTH];
    logic [GRLEN-1:0] q_data [QDEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr1;

    logic             live0;
    logic             live1;
    logic             push;
    logic [1:0]       pops;
    logic             has1;
    logic             has2;
    logic [4:0]       h0_addr;
    logic [4:0]       h1_addr;
    logic [GRLEN-1:0] h0_data;
    logic [GRLEN-1:0] h1_data;
    logic [4:0]       alu_addr;

    logic             wen1_n;
    logic [4:0]       waddr1_n;
    logic [GRLEN-1:0] wdata1_n;
    logic             wen2_n;
    logic [4:0]       waddr2_n;
    logic [GRLEN-1:0] wdata2_n;

    assign src2_ready = !rst && (q_count < CW'(QDEPTH));
    assign push = src2_valid && src2_ready && (src2_addr != 5'd0) && !flush;

    assign rd_ptr1 = rd_ptr + PW'(1);
    assign h0_addr = q_addr[rd_ptr];
    assign h0_data = q_data[rd_ptr];
    assign h1_addr = q_addr[rd_ptr1];
    assign h1_data = q_data[rd_ptr1];
    assign has1    = q_count >= CW'(1);
    assign has2    = q_count >= CW'(2);

    // src0 loses to a same-register src1 in the same cycle (src1 is younger).
    assign live0 = src0_valid && (src0_addr != 5'd0) &&
                   !(src1_valid && (src1_addr == src0_addr));
    assign live1 = src1_valid && (src1_addr != 5'd0);
    assign alu_addr = live0 ? src0_addr : src1_addr;

    always_comb begin
        pops     = 2'd0;
        wen1_n   = live0;
        waddr1_n = live0 ? src0_addr : 5'd0;
        wdata1_n = live0 ? src0_data : '0;
        wen2_n   = live1;
        waddr2_n = live1 ? src1_addr : 5'd0;
        wdata2_n = live1 ? src1_data : '0;
        if (!flush) begin
            if (!live0 && !live1) begin
                if (has2) begin
                    pops     = 2'd2;
                    // Older head is dead if head+1 targets the same register.
                    if (h0_addr != h1_addr) begin
                        wen1_n   = 1'b1;
                        waddr1_n = h0_addr;
                        wdata1_n = h0_data;
                    end
                    wen2_n   = 1'b1;
                    waddr2_n = h1_addr;
                    wdata2_n = h1_data;
                end else if (has1) begin
                    pops     = 2'd1;
                    wen1_n   = 1'b1;
                    waddr1_n = h0_addr;
                    wdata1_n = h0_data;
                end
            end else if (!(live0 && live1) && has1) begin
                pops = 2'd1;
                // A head hitting the live ALU register is stale: drop it.
                if (h0_addr != alu_addr) begin
                    if (live0) begin
                        wen2_n   = 1'b1;
                        waddr2_n = h0_addr;
                        wdata2_n = h0_data;
                    end else begin
                        wen1_n   = 1'b1;
                        waddr1_n = h0_addr;
                        wdata1_n = h0_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= src2_addr;
            q_data[wr_ptr] <= src2_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            wen1    <= 1'b0;
            waddr1  <= 5'd0;
            wdata1  <= '0;
            wen2    <= 1'b0;
            waddr2  <= 5'd0;
            wdata2  <= '0;
        end else begin
            wen1   <= wen1_n;
            waddr1 <= waddr1_n;
            wdata1 <= wdata1_n;
            wen2   <= wen2_n;
            waddr2 <= waddr2_n;
            wdata2 <= wdata2_n;
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                q_count <= '0;
            end else begin
                rd_ptr  <= rd_ptr + PW'(pops);
                wr_ptr  <= wr_ptr + PW'(push);
                q_count <= q_count + CW'(push) - CW'(pops);
            end
        end
    end

endmodule
